recip_seq_divider: RTL
======================

Name: recip_seq_divider

Overview:
- Sequential fixed-point reciprocal engine. Sits directly downstream of the 3-byte serial input loader and directly upstream of the byte-serial output stage.
- Takes a signed Q(WIDTH-FRAC).FRAC operand and computes 1/x by restoring long division of the constant 2^(2*FRAC) by |x|, one quotient bit per clock.
- Delivers a saturated WIDTH-bit result with a one-cycle done pulse, replacing a large combinational divider with a small iterative datapath.

Parameters:
- WIDTH, 24, operand/result width in bits, two's complement
- FRAC, 12, fractional bits of operand and result; 1.0 = 2^FRAC

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_start  input  1  request; sampled only while idle
- i_data  input  WIDTH  operand x, signed Q(WIDTH-FRAC).FRAC
- i_abs  input  1  1: return 1/|x| (always non-negative); 0: return signed 1/x
- o_busy  output  1  high while a division is in progress
- o_done  output  1  one-cycle pulse; o_data/o_sat valid in that cycle
- o_data  output  WIDTH  result, same Q format as input
- o_sat  output  1  result was clamped (zero divisor or overflow)

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All state changes on posedge clk only.
- Reset values: o_busy=0, o_done=0, o_data=0, o_sat=0; FSM enters IDLE.
- FSM states and transitions:
  - IDLE -> DIV: i_start=1 at an edge. On that edge capture i_data and i_abs, form magnitude |x| as WIDTH-bit unsigned (-2^(WIDTH-1) gives 2^(WIDTH-1)), record result sign = x[MSB] & ~i_abs, clear remainder/quotient, set o_busy.
  - DIV: exactly 2*FRAC+1 iterations, one per clock. Each iteration shifts the next dividend bit (MSB first) of 2^(2*FRAC) into the remainder; if remainder >= |x|, subtract and shift in quotient bit 1, else shift in 0. Remainder is WIDTH+1 bits wide; quotient is 2*FRAC+1 bits wide.
  - FIX: single cycle that rounds (optional), saturates, applies the sign, registers o_data/o_sat, pulses o_done, clears o_busy, then returns to IDLE.
- Latency: o_done is high in the cycle after edge E0+2*FRAC+2, where E0 is the accepting edge (26 clocks for the defaults). Latency is fixed and independent of the data, including the zero case.
- Saturation rules, applied to the quotient magnitude q:
  - Positive result: q > 2^(WIDTH-1)-1 gives 0x7FFFFF and o_sat=1.
  - Negative result: q > 2^(WIDTH-1) gives 0x800000 and o_sat=1.
- Zero divisor (|x|=0): o_data=0x7FFFFF, o_sat=1, irrespective of i_abs.
- Default rounding: truncation of the magnitude toward zero. Negation is applied after truncation.
- Output hold: o_data/o_sat hold their value from the last completed operation until the next FIX.
- i_start while busy: ignored. No queueing, and captured operands are not disturbed.
- Back-to-back operation: FIX returns to IDLE on the same edge that raises o_done, so i_start asserted during the o_done cycle is accepted on the next edge.
- Reset mid-operation: abort and return to IDLE with reset values. No o_done is produced for the aborted operation.

Optional Feature:
- Macro: RECIP_ROUND_EN.
- When defined, FIX rounds to nearest: if 2*remainder >= |x|, q is incremented before the saturation check. Ties round away from zero in magnitude.
- When undefined, the result is truncated; the rounding comparator and incrementer are not synthesised.
- Latency is identical in both builds.

Test Plan:
- i_data=0x001000 (1.0), i_abs=1, start -> o_done exactly 26 clocks after the accepting edge; o_data=0x001000, o_sat=0. Also i_data=0x002000 -> 0x000800.
- i_data=0xFFC000 (-4.0), i_abs=0 -> 0xFFFC00 (-0.25), o_sat=0. Same operand with i_abs=1 -> 0x000400.
- i_data=0x000000 -> 0x7FFFFF, o_sat=1. i_data=0x000001, i_abs=1 -> 0x7FFFFF, o_sat=1. i_data=0xFFFFFF, i_abs=0 -> 0x800000, o_sat=1.
- i_data=0x000006: without RECIP_ROUND_EN -> 0x2AAAAA; with RECIP_ROUND_EN -> 0x2AAAAB. i_data=0x000003 -> 0x555555 in both builds.
- Second i_start pulsed mid-operation -> ignored, first result unchanged. i_start held through the o_done cycle -> new operation accepted on the next edge, with o_busy high the following cycle.
- reset asserted at iteration 10 -> all outputs 0 next cycle, no o_done. A new start after reset release computes 0x002000 -> 0x000800 correctly.

Source files
------------

// File: rtl/recip_seq_divider_if.sv
// Request/result bundle for recip_seq_divider; the master drives operands, the slave returns results.
interface recip_seq_divider_if #(
  parameter int WIDTH = 24
);
  // Handshake: i_start is a request taken at a clock edge only while o_busy is low
  // (i_data/i_abs sampled on that same edge); o_done pulses for exactly one cycle
  // with o_data/o_sat valid, and o_data/o_sat then hold until the next result.
  logic             i_start;
  logic [WIDTH-1:0] i_data;
  logic             i_abs;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_data;
  logic             o_sat;

  modport master (
    output i_start, i_data, i_abs,
    input  o_busy, o_done, o_data, o_sat
  );

  modport slave (
    input  i_start, i_data, i_abs,
    output o_busy, o_done, o_data, o_sat
  );
endinterface

// File: rtl/recip_seq_divider.sv
// Sequential signed fixed-point reciprocal: restoring division of 2^(2*FRAC) by |x|, one bit per clock.
// Optional round-to-nearest is enabled by defining RECIP_ROUND_EN.
module recip_seq_divider #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 12
) (
  input  logic                clk,
  input  logic                reset,
  recip_seq_divider_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int QW    = 2*FRAC + 1;
  localparam int CNT_W = $clog2(QW + 1);
  localparam int CW    = (QW + 1 > WIDTH + 1) ? QW + 1 : WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] divisor, divisor_nxt;
  logic [WIDTH:0]   rem, rem_nxt;
  logic [QW-1:0]    quo, quo_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             neg, neg_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             sat_q, sat_nxt;

  logic [WIDTH+1:0] rem_sh;
  logic             fits;
  logic [CW-1:0]    q_mag;
  logic [CW-1:0]    pos_lim;
  logic [CW-1:0]    neg_lim;
  logic [WIDTH-1:0] q_trunc;

  // The dividend 2^(2*FRAC) has a single 1 at its MSB, so only the first iteration shifts in a 1.
  assign rem_sh  = {rem, (cnt == '0)};
  assign fits    = rem_sh >= {2'b00, divisor};
  assign pos_lim = CW'({1'b0, {(WIDTH-1){1'b1}}});
  assign neg_lim = CW'({1'b1, {(WIDTH-1){1'b0}}});

`ifdef RECIP_ROUND_EN
  logic round_up;
  assign round_up = {rem, 1'b0} >= {2'b00, divisor};
  assign q_mag    = CW'(quo) + CW'(round_up);
`else
  assign q_mag    = CW'(quo);
`endif
  assign q_trunc = q_mag[WIDTH-1:0];

  always_comb begin
    state_nxt   = state;
    divisor_nxt = divisor;
    rem_nxt     = rem;
    quo_nxt     = quo;
    cnt_nxt     = cnt;
    neg_nxt     = neg;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    data_nxt    = data_q;
    sat_nxt     = sat_q;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          divisor_nxt = bus.i_data[WIDTH-1] ? -bus.i_data : bus.i_data;
          neg_nxt     = bus.i_data[WIDTH-1] & ~bus.i_abs;
          rem_nxt     = '0;
          quo_nxt     = '0;
          cnt_nxt     = '0;
          busy_nxt    = 1'b1;
          state_nxt   = DIV;
        end
      end
      DIV: begin
        rem_nxt = fits ? (WIDTH+1)'(rem_sh - {2'b00, divisor}) : rem_sh[WIDTH:0];
        quo_nxt = {quo[QW-2:0], fits};
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(QW - 1)) state_nxt = FIX;
      end
      FIX: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
        if (divisor == '0) begin
          data_nxt = {1'b0, {(WIDTH-1){1'b1}}};
          sat_nxt  = 1'b1;
        end else if (!neg) begin
          sat_nxt  = q_mag > pos_lim;
          data_nxt = sat_nxt ? {1'b0, {(WIDTH-1){1'b1}}} : q_trunc;
        end else begin
          // Magnitude 2^(WIDTH-1) is still representable as the most negative value.
          sat_nxt  = q_mag > neg_lim;
          data_nxt = sat_nxt ? {1'b1, {(WIDTH-1){1'b0}}} : -q_trunc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      divisor <= divisor_nxt;
      rem     <= rem_nxt;
      quo     <= quo_nxt;
      cnt     <= cnt_nxt;
      neg     <= neg_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      data_q  <= data_nxt;
      sat_q   <= sat_nxt;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_data = data_q;
  assign bus.o_sat  = sat_q;
  assign state_dbg  = state;
endmodule
